lram_fill_arb: RTL and testbench
================================

# lram_fill_arb

Line-RAM fill scheduler for the video output path. On each line-start pulse from the sync generator, it selects the back half of the double-buffered line RAM and optionally clears it. It then shares the single write port among three layer requesters (text, graphic, sprite) with round-robin arbitration until all three report line-done. It flags an overrun when the next line starts before the fill has finished.

## Interface
- `LINE_WORDS`, 1024: words per line-RAM bank; the clear phase writes addresses 0..LINE_WORDS-1. Must be at most 1024.
- `CLEAR_WORD`, 16'h0000: transparent value written during the clear phase.

- `gclk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `hcomp` in 1: one-cycle line-start pulse, same cycle as the sync generator's HCOMP.
- `vrtc` in 1: vertical blank (1 = blank), sampled at `hcomp`.
- `lramsel_in` in 1: display bank select, sampled at `hcomp`.
- `req` in 3: per-requester write request; requester 0 is text, 1 graphic, 2 sprite.
- `req_addr` in 30: `{addr2, addr1, addr0}`, 10 bits each.
- `req_data` in 48: `{data2, data1, data0}`, 16 bits each.
- `req_done` in 3: line-done pulse or level, one bit per requester.
- `gnt` out 3: one-hot grant, combinational.
- `wr_en` out 1: line-RAM write strobe, registered.
- `wr_bank` out 1: target bank, registered.
- `wr_addr` out 10: line-RAM word address, registered.
- `wr_data` out 16: line-RAM write data, registered.
- `busy` out 1: high in CLEAR or FILL.
- `overrun` out 1: one-cycle pulse.
- `overrun_cnt` out 8: saturating count of overruns.

## Operation
- States: IDLE, CLEAR, FILL, DONE.
- IDLE/DONE + `hcomp`:
  - If `vrtc`=1, go to (or stay in) IDLE with no writes.
  - Otherwise latch `wr_bank` <= `lramsel_in`. This is the pre-toggle value, i.e. the bank leaving display.
  - Clear `done_seen[2:0]`, load `clr_addr`=0, and go to CLEAR.
- CLEAR:
  - Each cycle writes `CLEAR_WORD` at `clr_addr`, then increments it.
  - After the write of LINE_WORDS-1, go to FILL.
  - `gnt`=0 throughout.
- FILL:
  - At most one grant per cycle.
  - Round-robin pointer `rr`: search order starts at `rr`; on a grant, `rr` <= granted index + 1 (mod 3).
  - A requester holds `req`, `addr`, `data` stable until it sees `gnt`. The write is issued from the granted requester's addr/data.
  - `req` with `done_seen` set for that requester is ignored.
  - `req_done[i]` sets `done_seen[i]` in any cycle of CLEAR or FILL.
  - When `done_seen`=3'b111, go to DONE. This also happens in the same cycle the last bit sets, and a grant issued in that cycle still writes.
- Overrun:
  - `hcomp` in CLEAR or FILL with `vrtc`=0: pulse `overrun`, increment `overrun_cnt` (saturates at 255), then restart as from IDLE (new bank latch, CLEAR).
  - `hcomp` in CLEAR or FILL with `vrtc`=1: pulse `overrun`, go to IDLE.
- Address width: `clr_addr` is 11 bits internally for the terminal compare; `wr_addr` takes the low 10 bits.
- `rr` persists across lines and is reset only by `rst`.

## Timing
- Grant to write: `gnt[i]` is high in cycle N; `wr_en`/`wr_addr`/`wr_data` reflect that request in cycle N+1. Latency is 1.
- `hcomp` to first clear write: `hcomp` in cycle N, state is CLEAR in N+1, `wr_en` first high in N+2 with `wr_addr`=0.
- CLEAR lasts exactly LINE_WORDS cycles; `wr_en` is continuous through it.
- First possible grant is cycle N+1+LINE_WORDS.
- `busy` is registered and follows the state: high in the cycles whose state is CLEAR or FILL.
- `overrun` is registered: high in the cycle after the offending `hcomp`.
- On an overrun, a write already registered from cycle N still completes. No grant is issued in the `hcomp` cycle.
- Reset values: state IDLE, `gnt`=0, `wr_en`=0, `wr_bank`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `overrun`=0, `overrun_cnt`=0, `rr`=0, `done_seen`=0.
- `rst` mid-line abandons the fill immediately. Requesters must drop `req` during reset.

## Configuration
- `LFA_CLEAR_EN` defined: CLEAR phase as above.
- `LFA_CLEAR_EN` undefined:
  - CLEAR state and `clr_addr` are not built.
  - `hcomp` goes directly to FILL; first grant possible in cycle N+1.
  - Layers must then cover every address themselves.

## Test plan
- Reset then `hcomp` with `vrtc`=0, `lramsel_in`=1 -> `wr_bank`=1 and 1024 consecutive writes of 0x0000 at addresses 0..1023 starting N+2. Then `req`=3'b111 held -> grants cycle 0,1,2,0,… and `wr_data` follows the granted requester one cycle later.
- `req_done` for all three asserted during CLEAR -> FILL lasts one cycle, state DONE, `busy` low from N+1026. Later `req` pulses produce no `gnt`.
- Second `hcomp` arrives while in FILL -> `overrun`=1 for one cycle, `overrun_cnt`=1, CLEAR restarts at address 0 on the new bank. Repeat 300 times -> `overrun_cnt`=255.
- `hcomp` with `vrtc`=1 -> no `wr_en` and state IDLE. `hcomp` with `vrtc`=1 during FILL -> `overrun` pulse and IDLE.
- `rst` asserted mid-CLEAR at address 500 -> next cycle all outputs at reset values. The next `hcomp` starts from address 0.
- Build without `LFA_CLEAR_EN`: `hcomp` in cycle N with `req`=3'b010 -> `gnt`=3'b010 at N+1 and write at N+2.

Source files
------------

// File: rtl/lram_fill_arb_if.sv
// ============================================================================
//  Module      : lram_fill_arb_if
//  Description : Layer-requester / line-RAM write bundle for lram_fill_arb.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lram_fill_arb_if;
    logic        hcomp;
    logic        vrtc;
    logic        lramsel_in;
    logic [2:0]  req;
    logic [29:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  req_done;
    logic [2:0]  gnt;
    logic        wr_en;
    logic        wr_bank;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        overrun;
    logic [7:0]  overrun_cnt;

    modport master (
        output hcomp, vrtc, lramsel_in, req, req_addr, req_data, req_done,
        input  gnt, wr_en, wr_bank, wr_addr, wr_data, busy, overrun, overrun_cnt
    );

    modport slave (
        input  hcomp, vrtc, lramsel_in, req, req_addr, req_data, req_done,
        output gnt, wr_en, wr_bank, wr_addr, wr_data, busy, overrun, overrun_cnt
    );
endinterface

`default_nettype wire

// File: rtl/lram_fill_arb.sv
// ============================================================================
//  Module      : lram_fill_arb
//  Description : Line-RAM fill scheduler: optional bank clear, then round-robin
//                write-port sharing between text/graphic/sprite layers.
//                Build macro LFA_CLEAR_EN enables the clear phase.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lram_fill_arb #(
    parameter int          LINE_WORDS = 1024,
    parameter logic [15:0] CLEAR_WORD = 16'h0000
) (
    input  wire logic      gclk,
    input  wire logic      rst,
    lram_fill_arb_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

`ifdef LFA_CLEAR_EN
    localparam logic [1:0]  c_start_state = S_CLEAR;
    localparam logic [10:0] c_clr_last    = 11'(LINE_WORDS - 1);
`else
    localparam logic [1:0]  c_start_state = S_FILL;
`endif

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  r_rr;
    logic [2:0]  r_done_seen;
    logic [2:0]  w_done_nxt;
    logic        w_active;
    logic        w_start;
    logic        w_overrun;
    logic [2:0]  w_elig;
    logic [2:0]  w_gnt;
    logic [1:0]  w_gnt_idx;
    logic [1:0]  w_cand;
    logic        w_clr_wr;
    logic        w_busy_nxt;
    logic [9:0]  w_sel_addr;
    logic [15:0] w_sel_data;

    logic        r_wr_en;
    logic        r_wr_bank;
    logic [9:0]  r_wr_addr;
    logic [15:0] r_wr_data;
    logic        r_busy;
    logic        r_overrun;
    logic [7:0]  r_overrun_cnt;

`ifdef LFA_CLEAR_EN
    logic [10:0] r_clr_addr;
`else
    logic        w_unused_cfg;
    assign w_unused_cfg = ^{CLEAR_WORD, 32'(LINE_WORDS)};
`endif

    assign w_active   = (r_state == S_CLEAR) || (r_state == S_FILL);
    assign w_start    = bus.hcomp && !bus.vrtc;
    assign w_overrun  = bus.hcomp && w_active;
    assign w_done_nxt = r_done_seen | (w_active ? bus.req_done : 3'b000);

    // ---------------------------------------------------------------- state
    always_ff @(posedge gclk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        if (bus.hcomp) begin
            w_state_nxt = bus.vrtc ? S_IDLE : c_start_state;
        end else begin
            case (r_state)
`ifdef LFA_CLEAR_EN
                S_CLEAR: if (r_clr_addr == c_clr_last) w_state_nxt = S_FILL;
`endif
                S_FILL:  if (w_done_nxt == 3'b111) w_state_nxt = S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // ------------------------------------------------------------------ outputs
    // Later (lower k) candidates override, so the first eligible index in
    // search order starting at r_rr wins.
    always_comb begin
        w_elig    = bus.req & ~r_done_seen &
                    {3{(r_state == S_FILL) && !bus.hcomp && !rst}};
        w_gnt     = 3'b000;
        w_gnt_idx = 2'd0;
        w_cand    = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            w_cand = 2'((32'(r_rr) + 32'(k)) % 3);
            if (w_elig[w_cand]) begin
                w_gnt     = 3'b001 << w_cand;
                w_gnt_idx = w_cand;
            end
        end
        w_clr_wr   = (r_state == S_CLEAR) && !bus.hcomp;
        w_busy_nxt = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_FILL);
        case (w_gnt_idx)
            2'd1:    begin w_sel_addr = bus.req_addr[19:10]; w_sel_data = bus.req_data[31:16]; end
            2'd2:    begin w_sel_addr = bus.req_addr[29:20]; w_sel_data = bus.req_data[47:32]; end
            default: begin w_sel_addr = bus.req_addr[9:0];   w_sel_data = bus.req_data[15:0];  end
        endcase
    end

    // -------------------------------------------------------- registered datapath
    always_ff @(posedge gclk) begin
        if (rst) begin
            r_rr          <= 2'd0;
            r_done_seen   <= 3'b000;
            r_wr_en       <= 1'b0;
            r_wr_bank     <= 1'b0;
            r_wr_addr     <= 10'd0;
            r_wr_data     <= 16'd0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_overrun_cnt <= 8'd0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_overrun <= w_overrun;
            if (w_overrun && !bus.vrtc && (r_overrun_cnt != 8'hFF)) begin
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end
            if (w_start) begin
                r_wr_bank   <= bus.lramsel_in;
                r_done_seen <= 3'b000;
            end else begin
                r_done_seen <= w_done_nxt;
            end
            r_wr_en <= 1'b0;
            if (|w_gnt) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
                r_rr      <= (w_gnt_idx == 2'd2) ? 2'd0 : w_gnt_idx + 2'd1;
            end
`ifdef LFA_CLEAR_EN
            else if (w_clr_wr) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_clr_addr[9:0];
                r_wr_data <= CLEAR_WORD;
            end
`endif
        end
    end

`ifdef LFA_CLEAR_EN
    always_ff @(posedge gclk) begin
        if (rst) begin
            r_clr_addr <= 11'd0;
        end else if (w_start) begin
            r_clr_addr <= 11'd0;
        end else if (w_clr_wr) begin
            r_clr_addr <= r_clr_addr + 11'd1;
        end
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = w_clr_wr;
`endif

    assign bus.gnt         = w_gnt;
    assign bus.wr_en       = r_wr_en;
    assign bus.wr_bank     = r_wr_bank;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;
    assign bus.busy        = r_busy;
    assign bus.overrun     = r_overrun;
    assign bus.overrun_cnt = r_overrun_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lram_fill_arb.sv
// ============================================================================
//  Module      : tb_lram_fill_arb
//  Description : Randomized scoreboard bench for lram_fill_arb.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lram_fill_arb;

    localparam int          LW = 1024;
    localparam logic [15:0] CW = 16'h0000;
`ifdef LFA_CLEAR_EN
    localparam bit HAS_CLR = 1'b1;
`else
    localparam bit HAS_CLR = 1'b0;
`endif

    logic gclk = 1'b0;
    logic rst  = 1'b1;
    always #5 gclk = ~gclk;

    lram_fill_arb_if bus ();

    lram_fill_arb #(.LINE_WORDS(LW), .CLEAR_WORD(CW)) dut (
        .gclk (gclk),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct {
        int        tag;
        bit        bank;
        bit [9:0]  addr;
        bit [15:0] data;
    } wr_t;

    typedef enum int {P_IDLE, P_CLEAR, P_FILL, P_DONE} phase_t;

    wr_t      exp_q[$];
    int       n_cmp = 0;
    int       n_err = 0;
    int       cyc   = 0;
    bit [2:0] g_seen = 3'b000;
    bit       req_en = 1'b0;
    bit       dn_rand = 1'b0;

    // reference model state
    phase_t   ph = P_IDLE;
    int       m_rr = 0;
    int       m_clr = 0;
    bit [2:0] m_done = 3'b000;
    bit       m_bank = 1'b0;
    bit       m_busy = 1'b0;
    bit       m_ovr = 1'b0;
    int       m_cnt = 0;
    bit [2:0] e_gnt = 3'b000;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void push_wr(bit b, bit [9:0] a, bit [15:0] d);
        wr_t w;
        w.tag = cyc + 1; w.bank = b; w.addr = a; w.data = d;
        exp_q.push_back(w);
    endfunction

    // One clock of behaviour from the rules: grant search, clear walk, phase moves.
    function automatic void model_step();
        bit act;
        e_gnt = 3'b000;
        if (rst) begin
            ph = P_IDLE; m_rr = 0; m_clr = 0; m_done = 3'b000;
            m_bank = 1'b0; m_busy = 1'b0; m_ovr = 1'b0; m_cnt = 0;
            return;
        end
        act = (ph == P_CLEAR) || (ph == P_FILL);
        if (ph == P_FILL && !bus.hcomp) begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_rr + k) % 3;
                if (bus.req[i] && !m_done[i]) begin
                    e_gnt[i] = 1'b1;
                    push_wr(m_bank, bus.req_addr[i*10 +: 10], bus.req_data[i*16 +: 16]);
                    m_rr = (i + 1) % 3;
                    break;
                end
            end
        end
        if (ph == P_CLEAR && !bus.hcomp) push_wr(m_bank, m_clr[9:0], CW);
        m_ovr = bus.hcomp && act;
        if (m_ovr && !bus.vrtc && m_cnt < 255) m_cnt++;
        if (act) m_done |= bus.req_done;
        if (bus.hcomp) begin
            if (bus.vrtc) ph = P_IDLE;
            else begin
                m_bank = bus.lramsel_in; m_done = 3'b000; m_clr = 0;
                ph = HAS_CLR ? P_CLEAR : P_FILL;
            end
        end else if (ph == P_CLEAR) begin
            m_clr++;
            if (m_clr == LW) ph = P_FILL;
        end else if (ph == P_FILL && m_done == 3'b111) begin
            ph = P_DONE;
        end
        m_busy = (ph == P_CLEAR) || (ph == P_FILL);
    endfunction

    always @(posedge gclk) cyc <= cyc + 1;

    // registered outputs vs model, then grant prediction for this cycle
    always @(negedge gclk) begin
        if (cyc > 0) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("overrun", 32'(bus.overrun), 32'(m_ovr));
            check("overrun_cnt", 32'(bus.overrun_cnt), 32'(m_cnt));
            check("wr_bank", 32'(bus.wr_bank), 32'(m_bank));
        end
        model_step();
        if (cyc > 0) check("gnt", 32'(bus.gnt), 32'(e_gnt));
        g_seen = bus.gnt;
    end

    // write monitor: pops the scoreboard whenever the DUT writes
    always @(negedge gclk) begin
        if (cyc > 0) begin
            if (bus.wr_en === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].tag != cyc) begin
                    check("unexpected_write", 32'(bus.wr_addr), 32'hFFFF_FFFF);
                end else begin
                    check("wr_bank_w", 32'(bus.wr_bank), 32'(exp_q[0].bank));
                    check("wr_addr", 32'(bus.wr_addr), 32'(exp_q[0].addr));
                    check("wr_data", 32'(bus.wr_data), 32'(exp_q[0].data));
                    void'(exp_q.pop_front());
                end
            end else if (exp_q.size() != 0 && exp_q[0].tag == cyc) begin
                check("missing_write", 32'(bus.wr_en), 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input bit h, input bit v, input bit sel, input bit [2:0] dn, input bit r);
        @(posedge gclk);
        #1;
        rst = r;
        bus.hcomp      = h;
        bus.vrtc       = v;
        bus.lramsel_in = sel;
        bus.req_done   = dn;
        if (dn_rand && $urandom_range(0, 29) == 0) bus.req_done[$urandom_range(0, 2)] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                bus.req[i] = 1'b0;
            end else if (!bus.req[i] || g_seen[i]) begin
                bus.req[i] = req_en && ($urandom_range(0, 3) != 0);
                bus.req_addr[i*10 +: 10] = 10'($urandom);
                bus.req_data[i*16 +: 16] = 16'($urandom);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    initial begin
        bus.hcomp = 1'b0; bus.vrtc = 1'b0; bus.lramsel_in = 1'b0;
        bus.req = 3'b000; bus.req_addr = '0; bus.req_data = '0; bus.req_done = 3'b000;
        for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        idle(3);

        // full line on bank 1 with all requesters active
        req_en = 1'b1;
        step(1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
        idle(LW + 40);
        step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0);
        idle(10);

        // all layers finish during the clear phase
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        idle(10);
        step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0);
        idle(LW + 10);

        // blanking line start: no writes
        step(1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
        idle(8);

        // overrun in FILL: restart, then blanking overrun to IDLE
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        idle(LW + 20);
        step(1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
        idle(LW + 20);
        step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        idle(5);

        // counter saturation
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        for (int j = 0; j < 300; j++) begin
            idle(3);
            step(1'b1, 1'b0, 1'($urandom), 3'b000, 1'b0);
        end
        idle(3);
        step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        idle(3);

        // reset in the middle of a line, then restart from address 0
        step(1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
        idle(500);
        step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        idle(40);

        // random lines
        dn_rand = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step(1'b1, ($urandom_range(0, 4) == 0), 1'($urandom), 3'b000, 1'b0);
            idle($urandom_range(LW / 2, LW + 200));
        end
        dn_rand = 1'b0;
        req_en  = 1'b0;
        idle(10);

        check("leftover_writes", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
